// File: rtl/mcp3_rra03_if.sv
// mcp3_rra03 request/grant bundle.
// Master drives requests; slave (the arbiter) drives grants and status.
interface mcp3_rra03_if;
    logic [2:0] req;
    logic       rel;
    logic [2:0] grant;
    logic       grant_valid;
    logic       hold_timeout;
    logic       one_hot_error;

    modport master (
        output req,
        output rel,
        input  grant,
        input  grant_valid,
        input  hold_timeout,
        input  one_hot_error
    );

    modport slave (
        input  req,
        input  rel,
        output grant,
        output grant_valid,
        output hold_timeout,
        output one_hot_error
    );
endinterface

// File: rtl/mcp3_rra03.sv
// mcp3_rra03: three-way round-robin arbiter with hold limit
// and a sticky one-hot integrity error on pointer and grant.
module mcp3_rra03 #(
    parameter int HOLD_MAX = 16
) (
    input logic          clock,
    input logic          reset,
    mcp3_rra03_if.slave  bus
);

    localparam int CW = $clog2(HOLD_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic {
        IDLE,
        OWNED
    } state_t;

    state_t        state;
    logic [2:0]    grant;
    logic          grant_valid;
    logic          hold_timeout;
    logic          one_hot_error;
    logic [2:0]    last_winner;
    logic [CW-1:0] hold_cnt;

    logic [2:0]    others;
    logic [2:0]    win_idle;
    logic [2:0]    win_hand;
    logic          lw_bad;
    logic          grant_bad;

    // First set request bit after the pointer, wrapping 0->1->2->0.
    // A corrupt pointer falls back to bit 0 first so the grant
    // stays one-hot even while the error flag is raised.
    function automatic logic [2:0] pick(
        input logic [2:0] ptr,
        input logic [2:0] r
    );
        logic [2:0] w;
        w = '0;
        case (ptr)
            3'b001: begin
                if (r[1])      w = 3'b010;
                else if (r[2]) w = 3'b100;
                else if (r[0]) w = 3'b001;
            end
            3'b010: begin
                if (r[2])      w = 3'b100;
                else if (r[0]) w = 3'b001;
                else if (r[1]) w = 3'b010;
            end
            default: begin
                if (r[0])      w = 3'b001;
                else if (r[1]) w = 3'b010;
                else if (r[2]) w = 3'b100;
            end
        endcase
        return w;
    endfunction

    function automatic logic onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    // Winner selection and integrity checks on current state.
    always_comb begin
        others    = bus.req & ~grant;
        win_idle  = pick(last_winner, bus.req);
        win_hand  = pick(last_winner, others);
        lw_bad    = !onehot3(last_winner);
        grant_bad = grant_valid ? !onehot3(grant)
                                : (grant != 3'b000);
    end

    // Arbitration FSM with registered grant, timeout and error.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            grant         <= '0;
            grant_valid   <= 1'b0;
            hold_timeout  <= 1'b0;
            one_hot_error <= 1'b0;
            last_winner   <= 3'b100;
            hold_cnt      <= '0;
        end else begin
            hold_timeout <= 1'b0;
            if (lw_bad || grant_bad)
                one_hot_error <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (|bus.req) begin
                        state       <= OWNED;
                        grant       <= win_idle;
                        grant_valid <= 1'b1;
                        last_winner <= win_idle;
                        hold_cnt    <= '0;
                    end
                end
                OWNED: begin
                    if (bus.rel) begin
                        if (|others) begin
                            grant       <= win_hand;
                            last_winner <= win_hand;
                            hold_cnt    <= '0;
                        end else begin
                            state       <= IDLE;
                            grant       <= '0;
                            grant_valid <= 1'b0;
                        end
                    end else if (hold_cnt >= CNT_LAST) begin
                        state        <= IDLE;
                        grant        <= '0;
                        grant_valid  <= 1'b0;
                        hold_timeout <= 1'b1;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.grant         = grant;
    assign bus.grant_valid   = grant_valid;
    assign bus.hold_timeout  = hold_timeout;
    assign bus.one_hot_error = one_hot_error;

endmodule

// File: doc/mcp3_rra03.md
# mcp3_rra03

Three-requestor round-robin arbiter that produces a registered one-hot grant vector, the generating end of the 3-bit one-hot select paths in the AFP. A grant is held until the owner signals release or a hold limit expires. The block self-checks its rotation pointer and grant vector for one-hot integrity and reports a sticky error for the AFP error-capture logic.

## Interface
- HOLD_MAX, 16: maximum consecutive cycles a grant may be held; legal range 1..255.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
- req  in  3  request vector; bit i is requestor i; any combination legal.
- release  in  1  current owner done; sampled only while grant_valid=1.
- grant  out  3  registered grant; one-hot while grant_valid=1, 3'b000 otherwise.
- grant_valid  out  1  a grant is active.
- hold_timeout  out  1  one-cycle pulse when a grant is forcibly withdrawn at HOLD_MAX.
- one_hot_error  out  1  sticky; pointer or grant vector failed one-hot integrity.

## Operation
- State machine with two states, IDLE and OWNED. Reset state is IDLE.
- last_winner: 3-bit one-hot register. Reset value is 3'b100, so bit 0 has first priority after reset.
- Rotation order is 0->1->2->0. The winner is the first set req bit after the last_winner position, wrapping.
- IDLE: if req!=0, load grant with the winner, set grant_valid, update last_winner to the winner, clear hold_cnt, and go to OWNED. Otherwise hold all outputs at 0.
- OWNED: grant is held constant. hold_cnt increments each cycle.
  - Deassertion of the owner's req without release does not drop the grant.
- Release while OWNED, with req excluding the current owner nonzero: back-to-back handoff. Next cycle grant becomes the new rotation winner, last_winner updates, hold_cnt clears, and the state stays OWNED.
  - The current owner's req bit is masked for this handoff decision. This guarantees rotation.
- Release while OWNED, with no other request: next cycle grant=0, grant_valid=0, and the state goes to IDLE.
  - If the owner still requests, it may be re-granted one cycle later from IDLE.
- Timeout: if hold_cnt reaches HOLD_MAX-1 without release, the grant drops next cycle (grant=0, grant_valid=0, state IDLE) and hold_timeout pulses high in that same cycle. No handoff occurs on a timeout.
- Release and timeout in the same cycle: release wins, no hold_timeout pulse.
- release while IDLE is ignored.
- hold_cnt width is $clog2(HOLD_MAX+1) and it saturates; it never wraps.
- Integrity check, every cycle:
  - last_winner must be one-hot.
  - grant must be one-hot when grant_valid=1 and zero when grant_valid=0.
  - Any violation sets one_hot_error on the next edge. It holds until reset.
- Reset mid-grant: on the next edge, grant=0, grant_valid=0, hold_timeout=0, one_hot_error=0, last_winner=3'b100, hold_cnt=0, state IDLE.

## Timing
- Request-to-grant latency is 1 cycle: req sampled at edge N gives grant visible after edge N.
- Handoff latency is 1 cycle: release sampled at edge N gives the new grant (or 0) after edge N, with no idle bubble on a handoff.
- Grant duration is 1..HOLD_MAX cycles. The release-to-next-grant gap is 0 cycles on a handoff, 1 cycle via IDLE.
- hold_timeout is exactly 1 cycle wide, coincident with the first cycle of grant_valid=0.
- one_hot_error has a 1-cycle detection latency and is registered, with no combinational path from inputs.
- All outputs are registered. No input-to-output combinational paths.

## Test plan
- Reset then req=3'b111, with release pulsed on every grant cycle: grant sequence 001,010,100,001. Grant starts 1 cycle after req, handoffs back-to-back, no IDLE cycles.
- Idle start: req=3'b010 for one cycle only, then req=0, release never: grant=3'b010 for exactly 16 cycles. Then grant=0 and hold_timeout=1 for one cycle, one_hot_error=0.
- Release and timeout together: HOLD_MAX=4, release asserted in the 4th grant cycle: grant drops next cycle with hold_timeout=0.
- Rotation fairness: req=3'b101 constant, immediate release each grant: grant alternates 001,100,001,100. Bit 1 is never granted.
- Reset mid-operation: reset asserted while grant=3'b100: next cycle all outputs 0. With req=3'b111 after reset deasserts, the first grant is 3'b001.
- Error injection: force last_winner to 3'b011 for one cycle: one_hot_error=1 after the next edge and stays 1 until reset. Grant stays one-hot or zero.
